sym_vn_lut_loader: RTL and testbench
====================================

SYM_VN_LUT_LOADER -- requirements
Module: sym_vn_lut_loader

Interface
REQ-001 Parameter: DATA_WIDTH, 4, width of one IB-LUT entry.
REQ-002 Parameter: PAGE_ADDR_WIDTH, 6, width of page_write_addr.
REQ-003 Parameter: PAGE_NUM, 64, pages written per load (range 1..2^PAGE_ADDR_WIDTH).
REQ-004 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-005 write_clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 load_start  in  1  one-cycle request to begin a LUT load.
REQ-008 load_offset  in  1  page-address offset for this load, sampled with load_start.
REQ-009 load_abort  in  1  cancels a load in progress.
REQ-010 entry_in  in  DATA_WIDTH  LUT entry stream data.
REQ-011 entry_valid  in  1  entry_in is valid.
REQ-012 entry_ready  out  1  loader accepts entry_in this cycle.
REQ-013 lut_in_bank0  out  DATA_WIDTH  bank-0 write data to the LUT rank.
REQ-014 lut_in_bank1  out  DATA_WIDTH  bank-1 write data to the LUT rank.
REQ-015 page_write_addr  out  PAGE_ADDR_WIDTH  page being written.
REQ-016 write_addr_offset  out  1  page offset of the write.
REQ-017 we  out  1  write enable; one cycle per page.
REQ-018 busy  out  1  load in progress.
REQ-019 done  out  1  one-cycle pulse on load completion.

Function
REQ-020 An entry SHALL be accepted in any cycle where entry_valid and entry_ready are both 1; entry_in SHALL be ignored otherwise.
REQ-021 The FSM SHALL have states IDLE, BANK0, BANK1, FINISH.
REQ-022 IDLE: entry_ready=0, busy=0; load_start=1 -> BANK0, page counter cleared to 0, load_offset latched.
REQ-023 BANK0: entry_ready=1, busy=1; on accept, store entry in the bank-0 holding register -> BANK1.
REQ-024 BANK1: entry_ready=1, busy=1; on accept, the next cycle SHALL present we=1, lut_in_bank0=holding register, lut_in_bank1=accepted entry, page_write_addr=page counter, write_addr_offset=latched offset.
REQ-025 After a BANK1 accept, the page counter SHALL increment; if it was PAGE_NUM-1 the FSM -> FINISH, else -> BANK0.
REQ-026 Stream order: entry 2p is page p bank 0 and entry 2p+1 is page p bank 1, for p = 0..PAGE_NUM-1.
REQ-027 we SHALL be high for exactly one cycle per page; write data, address and offset SHALL hold their last values while we=0.
REQ-028 FINISH: entry_ready=0, busy=1; the FSM SHALL stay one cycle, the same cycle as the final we, with done=1, then -> IDLE.
REQ-029 Throughput: with entry_valid held high, one page SHALL be written every 2 cycles.
REQ-030 load_start while busy=1 SHALL be ignored and SHALL NOT change the latched offset.
REQ-031 load_abort=1 in BANK0 or BANK1 SHALL force IDLE next cycle with no further we and no done; a we already scheduled by a BANK1 accept in the same cycle SHALL still occur.
REQ-032 load_abort and load_start in the same IDLE cycle: abort SHALL win and the FSM SHALL remain IDLE.
REQ-033 A load_abort in FINISH SHALL be ignored; done SHALL still pulse.
REQ-034 The page counter SHALL never exceed PAGE_NUM-1, so no address wrap-around is possible.

Reset
REQ-035 While rst=1: state=IDLE, page counter=0, holding register=0, all outputs 0 (entry_ready, we, busy and done included).
REQ-036 Reset asserted mid-load SHALL abandon the load immediately, with no pending we and no done after release.

Verification
REQ-037 Full load: load_start with load_offset=1, then entries 0..127 (value = index mod 16) with valid always high -> 64 we pulses 2 cycles apart, page p carries bank0=(2p)mod16 and bank1=(2p+1)mod16, offset=1, done coincides with the page-63 we.
REQ-038 Bubbles: entry_valid toggled pseudo-randomly -> write data identical to REQ-037, with we only after each odd-indexed accept.
REQ-039 Abort after 10 entries -> exactly 5 we pulses (pages 0..4), no done, busy=0 next cycle; a following load_start succeeds from page 0.
REQ-040 load_start pulsed at page 20 -> ignored; offset unchanged; load completes normally.
REQ-041 rst asserted after entry 33 -> all outputs 0 asynchronously; no we or done after release; the next load starts at page 0.
REQ-042 PAGE_NUM=1 -> a single we at page 0 with done in the same cycle.

Source files
------------

// File: rtl/sym_vn_lut_loader_if.sv
// sym_vn_lut_loader_if: load control, entry stream and LUT write bus of the loader
interface sym_vn_lut_loader_if #(
  parameter int DATA_WIDTH      = 4,
  parameter int PAGE_ADDR_WIDTH = 6
);
  logic                       load_start;
  logic                       load_offset;
  logic                       load_abort;
  logic [DATA_WIDTH-1:0]      entry_in;
  logic                       entry_valid;
  logic                       entry_ready;
  logic [DATA_WIDTH-1:0]      lut_in_bank0;
  logic [DATA_WIDTH-1:0]      lut_in_bank1;
  logic [PAGE_ADDR_WIDTH-1:0] page_write_addr;
  logic                       write_addr_offset;
  logic                       we;
  logic                       busy;
  logic                       done;
  modport master (
    output load_start, load_offset, load_abort, entry_in, entry_valid,
    input  entry_ready, lut_in_bank0, lut_in_bank1, page_write_addr,
           write_addr_offset, we, busy, done
  );
  modport slave (
    input  load_start, load_offset, load_abort, entry_in, entry_valid,
    output entry_ready, lut_in_bank0, lut_in_bank1, page_write_addr,
           write_addr_offset, we, busy, done
  );
endinterface

// File: rtl/sym_vn_lut_loader.sv
// sym_vn_lut_loader: pairs a streamed entry sequence into per-page two-bank LUT writes
module sym_vn_lut_loader #(
  parameter int DATA_WIDTH      = 4,
  parameter int PAGE_ADDR_WIDTH = 6,
  parameter int PAGE_NUM        = 64
) (
  input  logic                  write_clk,
  input  logic                  rst,
  sym_vn_lut_loader_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, BANK0, BANK1, FINISH} state_t;
  localparam logic [PAGE_ADDR_WIDTH-1:0] LAST = PAGE_ADDR_WIDTH'(PAGE_NUM - 1);
  state_t                     state_q, state_d;
  logic [PAGE_ADDR_WIDTH-1:0] page_q, page_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      hold_q, hold_d, b0_q, b0_d, b1_q, b1_d;
  logic                       off_q, off_d, woff_q, woff_d, we_q, we_d;
  logic                       accept;
  assign accept = bus.entry_valid && bus.entry_ready;
  // state and datapath registers; reset abandons any load and any pending write
  always_ff @(posedge write_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      page_q  <= '0;
      hold_q  <= '0;
      off_q   <= 1'b0;
      we_q    <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
      addr_q  <= '0;
      woff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      hold_q  <= hold_d;
      off_q   <= off_d;
      we_q    <= we_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      addr_q  <= addr_d;
      woff_q  <= woff_d;
    end
  end
  // next state: a bank-1 accept schedules the page write even if abort lands in the same cycle
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    hold_d  = hold_q;
    off_d   = off_q;
    we_d    = 1'b0;
    b0_d    = b0_q;
    b1_d    = b1_q;
    addr_d  = addr_q;
    woff_d  = woff_q;
    case (state_q)
      IDLE: if (bus.load_start && !bus.load_abort) begin
        state_d = BANK0;
        page_d  = '0;
        off_d   = bus.load_offset;
      end
      BANK0: begin
        if (accept) begin
          hold_d  = bus.entry_in;
          state_d = BANK1;
        end
        if (bus.load_abort) state_d = IDLE;
      end
      BANK1: begin
        if (accept) begin
          we_d    = 1'b1;
          b0_d    = hold_q;
          b1_d    = bus.entry_in;
          addr_d  = page_q;
          woff_d  = off_q;
          page_d  = (page_q == LAST) ? '0 : page_q + 1'b1;
          state_d = (page_q == LAST) ? FINISH : BANK0;
        end
        if (bus.load_abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs: handshake and status decode from state, write bus straight from registers
  always_comb begin
    bus.entry_ready       = (state_q == BANK0) || (state_q == BANK1);
    bus.busy              = state_q != IDLE;
    bus.done              = state_q == FINISH;
    bus.we                = we_q;
    bus.lut_in_bank0      = b0_q;
    bus.lut_in_bank1      = b1_q;
    bus.page_write_addr   = addr_q;
    bus.write_addr_offset = woff_q;
  end
endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// tb_sym_vn_lut_loader: directed scoreboard bench for the LUT loader
module tb_sym_vn_lut_loader;
  typedef struct {
    int page;
    int b0;
    int b1;
    int off;
    int last;
  } exp_t;
  logic write_clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   prev_we = -1;
  bit   gap_mode = 1'b0;
  int   exp_off = 0;
  exp_t q[$];
  exp_t e_mon;
  exp_t e_drv;
  sym_vn_lut_loader_if #(.DATA_WIDTH(4), .PAGE_ADDR_WIDTH(6)) m();
  sym_vn_lut_loader_if #(.DATA_WIDTH(4), .PAGE_ADDR_WIDTH(6)) m1();
  sym_vn_lut_loader #(.DATA_WIDTH(4), .PAGE_ADDR_WIDTH(6), .PAGE_NUM(64)) dut (
    .write_clk(write_clk), .rst(rst), .bus(m.slave));
  sym_vn_lut_loader #(.DATA_WIDTH(4), .PAGE_ADDR_WIDTH(6), .PAGE_NUM(1)) dut1 (
    .write_clk(write_clk), .rst(rst), .bus(m1.slave));
  always #5 write_clk = ~write_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge write_clk);
    #1;
  endtask
  task automatic start_load(input logic o);
    m.load_start  = 1'b1;
    m.load_offset = o;
    step();
    m.load_start  = 1'b0;
    m.load_offset = 1'b0;
    exp_off = int'(o);
    chk("busy_after_start", 32'(m.busy), 1);
  endtask
  task automatic feed(input int n, input bit bub, input int spi);
    gap_mode = !bub;
    prev_we  = -1;
    for (int i = 0; i < n;) begin
      m.entry_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      m.entry_in    = 4'(i);
      m.load_start  = (i == spi);
      m.load_offset = (exp_off == 0);
      chk("entry_ready", 32'(m.entry_ready), 1);
      if (m.entry_valid) begin
        if (i % 2 == 1) begin
          e_drv.page = i / 2;
          e_drv.b0   = (i - 1) % 16;
          e_drv.b1   = i % 16;
          e_drv.off  = exp_off;
          e_drv.last = int'(i / 2 == 63);
          q.push_back(e_drv);
        end
        i++;
      end
      step();
    end
    m.entry_valid = 1'b0;
    m.load_start  = 1'b0;
    m.load_offset = 1'b0;
  endtask
  task automatic drain();
    repeat (3) step();
    chk("queue_drained", 32'(q.size()), 0);
    chk("busy_idle", 32'(m.busy), 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 32'(m.we), 0);
    chk({tag, "_busy"}, 32'(m.busy), 0);
    chk({tag, "_done"}, 32'(m.done), 0);
    chk({tag, "_ready"}, 32'(m.entry_ready), 0);
    chk({tag, "_bank0"}, 32'(m.lut_in_bank0), 0);
    chk({tag, "_bank1"}, 32'(m.lut_in_bank1), 0);
    chk({tag, "_addr"}, 32'(m.page_write_addr), 0);
    chk({tag, "_offset"}, 32'(m.write_addr_offset), 0);
  endtask
  // scoreboard: every write pops one expected page; done may only ride on the final write
  always @(negedge write_clk) begin
    cyc++;
    if (m.we === 1'b1) begin
      if (q.size() == 0) chk("unexpected_we", 32'(m.page_write_addr), 32'hFFFF_FFFF);
      else begin
        e_mon = q.pop_front();
        chk("page_addr", 32'(m.page_write_addr), 32'(e_mon.page));
        chk("bank0", 32'(m.lut_in_bank0), 32'(e_mon.b0));
        chk("bank1", 32'(m.lut_in_bank1), 32'(e_mon.b1));
        chk("offset", 32'(m.write_addr_offset), 32'(e_mon.off));
        chk("done_with_we", 32'(m.done), 32'(e_mon.last));
        if (gap_mode && prev_we >= 0) chk("we_gap", 32'(cyc - prev_we), 2);
        prev_we = cyc;
      end
    end else chk("stray_done", 32'(m.done), 0);
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    m.load_start   = 1'b0;
    m.load_offset  = 1'b0;
    m.load_abort   = 1'b0;
    m.entry_in     = '0;
    m.entry_valid  = 1'b0;
    m1.load_start  = 1'b0;
    m1.load_offset = 1'b0;
    m1.load_abort  = 1'b0;
    m1.entry_in    = '0;
    m1.entry_valid = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) step();
    rst = 1'b0;
    step();
    m.load_start = 1'b1;
    m.load_abort = 1'b1;
    step();
    m.load_start = 1'b0;
    m.load_abort = 1'b0;
    chk("abort_beats_start", 32'(m.busy), 0);
    start_load(1'b1);
    feed(128, 1'b0, -1);
    drain();
    start_load(1'b0);
    feed(128, 1'b1, -1);
    drain();
    start_load(1'b1);
    feed(10, 1'b0, -1);
    m.load_abort = 1'b1;
    step();
    m.load_abort = 1'b0;
    chk("abort_busy", 32'(m.busy), 0);
    chk("abort_ready", 32'(m.entry_ready), 0);
    drain();
    start_load(1'b1);
    feed(128, 1'b0, 40);
    drain();
    start_load(1'b0);
    feed(34, 1'b0, -1);
    rst = 1'b1;
    void'(q.pop_back());
    #1;
    chk_zero("midload_reset");
    repeat (2) step();
    rst = 1'b0;
    drain();
    start_load(1'b1);
    feed(128, 1'b0, -1);
    drain();
    m1.load_start  = 1'b1;
    m1.load_offset = 1'b1;
    step();
    m1.load_start  = 1'b0;
    m1.load_offset = 1'b0;
    m1.entry_valid = 1'b1;
    m1.entry_in    = 4'd9;
    step();
    m1.entry_in    = 4'd6;
    step();
    m1.entry_valid = 1'b0;
    chk("pn1_we", 32'(m1.we), 1);
    chk("pn1_done", 32'(m1.done), 1);
    chk("pn1_addr", 32'(m1.page_write_addr), 0);
    chk("pn1_bank0", 32'(m1.lut_in_bank0), 9);
    chk("pn1_bank1", 32'(m1.lut_in_bank1), 6);
    chk("pn1_offset", 32'(m1.write_addr_offset), 1);
    step();
    chk("pn1_we_after", 32'(m1.we), 0);
    chk("pn1_done_after", 32'(m1.done), 0);
    chk("pn1_busy_after", 32'(m1.busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
